// File: rtl/mips_mult_div.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Multiply is shift-add and divide is restoring, one bit per cycle over WIDTH
// cycles. A single FINISH cycle applies the sign fixup and loads HI/LO, and
// Done pulses in the following cycle with the new values already visible.
module mips_mult_div #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic             HiWrite,
    input  logic             LoWrite,
    input  logic [WIDTH-1:0] WriteData,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned ACC_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_FINISH  = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [1:0]         op_q, op_d;
    // Multiply: {running high half, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [ACC_W-1:0]   acc_q, acc_d;
    // |A| as multiplicand for multiply, |B| as divisor for divide.
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    // Unmodified dividend, returned in HI on divide-by-zero.
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Combinational helpers for acceptance, one iteration step and fixup.
    logic               signed_op;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [ACC_W-1:0]   prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign Busy = busy_q;
    assign Done = done_q;
    assign Hi   = hi_q;
    assign Lo   = lo_q;

    // Next-state, datapath step and output computation.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        op_d       = op_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        a_raw_d    = a_raw_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        // Op[0] set means the unsigned variant; unsigned operands stay raw.
        signed_op = ~Op[0];
        mag_a     = (signed_op && OperandA[WIDTH-1]) ? WIDTH'(-OperandA) : OperandA;
        mag_b     = (signed_op && OperandB[WIDTH-1]) ? WIDTH'(-OperandB) : OperandB;

        mul_sum   = {1'b0, acc_q[ACC_W-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, opnd_q} : (WIDTH+1)'(0));
        div_shift = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};

        prod_fix  = (sign_a_q ^ sign_b_q) ? ACC_W'(-acc_q) : acc_q;
        quot_fix  = (sign_a_q ^ sign_b_q) ? WIDTH'(-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        rem_fix   = sign_a_q ? WIDTH'(-acc_q[ACC_W-1:WIDTH]) : acc_q[ACC_W-1:WIDTH];

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (HiWrite || LoWrite) begin
                    // MTHI/MTLO win over a same-cycle Start.
                    if (HiWrite) hi_d = WriteData;
                    if (LoWrite) lo_d = WriteData;
                end else if (Start) begin
                    state_d    = ST_COMPUTE;
                    count_d    = CNT_W'(WIDTH - 1);
                    op_d       = Op;
                    a_raw_d    = OperandA;
                    sign_a_d   = signed_op & OperandA[WIDTH-1];
                    sign_b_d   = signed_op & OperandB[WIDTH-1];
                    div_zero_d = (OperandB == '0);
                    if (Op[1]) begin
                        acc_d  = {{WIDTH{1'b0}}, mag_a};
                        opnd_d = mag_b;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, mag_b};
                        opnd_d = mag_a;
                    end
                end
            end

            ST_COMPUTE: begin
                if (op_q[1]) begin
                    // Restoring divide: keep the subtraction only if it did not borrow.
                    if (!div_diff[WIDTH]) begin
                        acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    // Shift-add multiply: add on the LSB, then shift the whole accumulator right.
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                if (count_q == '0) begin
                    state_d = ST_FINISH;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end

            ST_FINISH: begin
                state_d = ST_DONE;
                if (op_q[1]) begin
                    if (div_zero_q) begin
                        lo_d = '1;
                        hi_d = a_raw_q;
                    end else begin
                        lo_d = quot_fix;
                        hi_d = rem_fix;
                    end
                end else begin
                    hi_d = prod_fix[ACC_W-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end

            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_COMPUTE) || (state_d == ST_FINISH);
        done_d = (state_d == ST_DONE);
    end

    // State, datapath and output registers; reset aborts any operation.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            op_q       <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            a_raw_q    <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            a_raw_q    <= a_raw_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_mips_mult_div.sv
// Randomized bench for mips_mult_div against an arithmetic reference model.
module tb_mips_mult_div;

    localparam int unsigned W = 32;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         Start;
    logic [1:0]   Op;
    logic [W-1:0] OperandA;
    logic [W-1:0] OperandB;
    logic         HiWrite;
    logic         LoWrite;
    logic [W-1:0] WriteData;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Hi;
    logic [W-1:0] Lo;

    int passed = 0;
    int total  = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    mips_mult_div #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .Start     (Start),
        .Op        (Op),
        .OperandA  (OperandA),
        .OperandB  (OperandB),
        .HiWrite   (HiWrite),
        .LoWrite   (LoWrite),
        .WriteData (WriteData),
        .Busy      (Busy),
        .Done      (Done),
        .Hi        (Hi),
        .Lo        (Lo)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // MIPS HI/LO semantics expressed with plain 64-bit arithmetic.
    task automatic ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] hi, output logic [W-1:0] lo);
        logic signed [63:0] sa, sb, sp, sq, sr;
        logic [63:0] ua, ub, up;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'b00: begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
            2'b01: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
            2'b10: begin
                if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    lo = sq[31:0];
                    hi = sr[31:0];
                end
            end
            default: begin
                if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
                else begin up = ua / ub; lo = up[31:0]; up = ua % ub; hi = up[31:0]; end
            end
        endcase
    endtask

    // Issue one operation at the current negedge; returns at the negedge where Done is seen.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit poke);
        logic [W-1:0] rh, rl;
        int n;
        int busy_cnt;
        bit seen;
        ref_op(op, a, b, rh, rl);
        Start = 1'b1; Op = op; OperandA = a; OperandB = b;
        HiWrite = 1'b0; LoWrite = 1'b0;
        @(negedge CLK);
        Start = 1'b0;
        OperandA = $urandom;
        OperandB = $urandom;
        n = 1; busy_cnt = 0; seen = 1'b0;
        while (n <= 60 && !seen) begin
            if (Done) seen = 1'b1;
            else begin
                if (Busy === 1'b1) busy_cnt++;
                if (n == 1) begin
                    check("hold_hi", 64'(Hi), 64'(exp_hi));
                    check("hold_lo", 64'(Lo), 64'(exp_lo));
                end
                if (poke && n == 5) begin
                    Start = 1'b1; HiWrite = 1'b1; LoWrite = 1'b1;
                    WriteData = $urandom; Op = ~op;
                end else begin
                    Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
                end
                @(negedge CLK);
                n++;
            end
        end
        Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
        check("done_latency", 64'(seen ? n : 0), 64'd34);
        check("busy_cycles", 64'(busy_cnt), 64'd33);
        check("busy_at_done", 64'(Busy), 64'd0);
        check("hi", 64'(Hi), 64'(rh));
        check("lo", 64'(Lo), 64'(rl));
        exp_hi = rh;
        exp_lo = rl;
    endtask

    // One idle cycle after an operation: Done must have been a single pulse.
    task automatic gap();
        @(negedge CLK);
        check("done_pulse", 64'(Done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int done_cnt;
        logic [1:0] rop;
        logic [W-1:0] ra, rb;
        RESET = 1'b1; Start = 1'b0; Op = '0; OperandA = '0; OperandB = '0;
        HiWrite = 1'b0; LoWrite = 1'b0; WriteData = '0;
        repeat (2) @(negedge CLK);
        check("rst_hi", 64'(Hi), 64'd0);
        check("rst_lo", 64'(Lo), 64'd0);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        RESET = 1'b0;
        @(negedge CLK);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0); gap();
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0);
        run_op(2'b00, 32'd0, 32'h1234_5678, 1'b0); gap();
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(2'b11, 32'd7, 32'd2, 1'b0);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_op(2'b11, 32'h0000_1234, 32'd0, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF0, 32'd0, 1'b0); gap();

        // MTLO with a same-cycle Start: write wins, no operation starts.
        Start = 1'b1; Op = 2'b01; OperandA = 32'd9; OperandB = 32'd9;
        LoWrite = 1'b1; WriteData = 32'hDEAD_BEEF;
        @(negedge CLK);
        Start = 1'b0; LoWrite = 1'b0;
        exp_lo = 32'hDEAD_BEEF;
        check("mtlo_lo", 64'(Lo), 64'(exp_lo));
        check("mtlo_hi", 64'(Hi), 64'(exp_hi));
        check("mtlo_busy", 64'(Busy), 64'd0);
        check("mtlo_done", 64'(Done), 64'd0);
        @(negedge CLK);
        check("mtlo_busy2", 64'(Busy), 64'd0);
        check("mtlo_done2", 64'(Done), 64'd0);

        // MTHI and MTLO together.
        HiWrite = 1'b1; LoWrite = 1'b1; WriteData = 32'h0BAD_F00D;
        @(negedge CLK);
        HiWrite = 1'b0; LoWrite = 1'b0;
        exp_hi = 32'h0BAD_F00D; exp_lo = 32'h0BAD_F00D;
        check("mthilo_hi", 64'(Hi), 64'(exp_hi));
        check("mthilo_lo", 64'(Lo), 64'(exp_lo));

        // Start/HiWrite mid-operation must be ignored.
        run_op(2'b01, 32'h0001_0003, 32'h0002_0005, 1'b1); gap();

        // Asynchronous reset partway through a DIVU.
        Start = 1'b1; Op = 2'b11; OperandA = 32'd1000; OperandB = 32'd7;
        @(negedge CLK);
        Start = 1'b0;
        repeat (9) @(negedge CLK);
        #2 RESET = 1'b1;
        #1;
        check("arst_hi", 64'(Hi), 64'd0);
        check("arst_lo", 64'(Lo), 64'd0);
        check("arst_busy", 64'(Busy), 64'd0);
        check("arst_done", 64'(Done), 64'd0);
        exp_hi = '0; exp_lo = '0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (Done === 1'b1 || Busy === 1'b1) done_cnt++;
        end
        check("arst_no_resume", 64'(done_cnt), 64'd0);
        run_op(2'b01, 32'd3, 32'd4, 1'b0); gap();

        // Randomized operations, sometimes back-to-back from DONE.
        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: ra = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op(rop, ra, rb, ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 1) == 0) gap();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
